// File: rtl/hwpf_pkg.sv
// Shared types and defaults for the next-line prefetch issue stage.
package hwpf_pkg;

   localparam int unsigned ADDR_W              = 40;
   localparam int unsigned DEF_MAX_OUTSTANDING = 4;
   localparam int unsigned DEF_LINE_OFF_BITS   = 6;
   localparam int unsigned DEF_FILTER_DEPTH    = 4;

   typedef logic [ADDR_W-1:0]                   cpu_addr_t;
   typedef logic [ADDR_W-DEF_LINE_OFF_BITS-1:0] line_addr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } hwpf_issue_state_t;

   // Mask that clears the byte-offset bits of a line.
   function automatic cpu_addr_t line_mask(input int unsigned off_bits);
      return ~((cpu_addr_t'(1) << off_bits) - cpu_addr_t'(1));
   endfunction

endpackage

// File: rtl/hwpf_recent_filter.sv
// Small FIFO of recently granted line addresses; flags candidates that hit a valid entry.
module hwpf_recent_filter
   import hwpf_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_FILTER_DEPTH,
   parameter int unsigned LINE_W = $bits(line_addr_t)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              ins_i,
   input  logic [LINE_W-1:0] ins_line_i,
   input  logic [LINE_W-1:0] chk_line_i,
   output logic              hit_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]  valid_q;
   logic [LINE_W-1:0] tag_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;

   // Combinational lookup across all valid entries.
   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] && (tag_q[i] == chk_line_i)) begin
            hit_o = 1'b1;
         end
      end
   end

   // Entry storage: clear drops everything; an insert in the same cycle still lands.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (clr_i) begin
            valid_q <= '0;
         end
         if (ins_i) begin
            valid_q[wr_ptr_q] <= 1'b1;
            tag_q[wr_ptr_q]   <= ins_line_i;
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
               wr_ptr_q <= '0;
            end else begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/hwpf_issue.sv
// Prefetch issue stage: pops stack candidates, line-aligns them, throttles on
// outstanding prefetches and drives the dcache req/gnt port.
// Optional recent-line filter enabled by defining HWPF_ISSUE_FILTER_EN.
module hwpf_issue
   import hwpf_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int unsigned LINE_OFF_BITS   = DEF_LINE_OFF_BITS
`ifdef HWPF_ISSUE_FILTER_EN
   ,
   parameter int unsigned FILTER_DEPTH    = DEF_FILTER_DEPTH
`endif
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      flush_i,
   input  logic      stall_i,
   input  logic      stk_valid_i,
   input  cpu_addr_t stk_addr_i,
   output logic      stk_pop_o,
   output logic      mem_req_o,
   output cpu_addr_t mem_addr_o,
   input  logic      mem_gnt_i,
   input  logic      mem_rsp_i,
   output logic      busy_o
);

   localparam int unsigned W     = $bits(cpu_addr_t);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam cpu_addr_t   LMASK = line_mask(LINE_OFF_BITS);

   hwpf_issue_state_t state_q;
   cpu_addr_t         addr_q;
   logic              req_q;
   logic [OUT_W-1:0]  outst_q;
   logic [OUT_W-1:0]  outst_d;
   logic              pop_c;
   logic              hit_c;
   logic              gnt_c;
   logic              rsp_c;

   // Pop only from IDLE, and only while there is room for another outstanding prefetch.
   assign pop_c = (state_q == IDLE) & stk_valid_i & ~stall_i & ~flush_i
                & (outst_q < OUT_W'(MAX_OUTSTANDING));
   assign gnt_c = (state_q == ISSUE) & mem_gnt_i;
   assign rsp_c = mem_rsp_i & (outst_q != '0);

`ifdef HWPF_ISSUE_FILTER_EN
   localparam int unsigned LINE_W = W - LINE_OFF_BITS;

   // Recently granted lines; a hit discards the popped candidate.
   hwpf_recent_filter #(
      .DEPTH  (FILTER_DEPTH),
      .LINE_W (LINE_W)
   ) u_filter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (flush_i),
      .ins_i      (gnt_c),
      .ins_line_i (addr_q[W-1:LINE_OFF_BITS]),
      .chk_line_i (stk_addr_i[W-1:LINE_OFF_BITS]),
      .hit_o      (hit_c)
   );
`else
   assign hit_c = 1'b0;
`endif

   // Outstanding counter: +1 per grant, -1 per response, responses at zero ignored.
   always_comb begin
      outst_d = outst_q;
      case ({gnt_c, rsp_c})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase
   end

   // Issue FSM with registered request/address; a raised request is held until granted or flushed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         req_q   <= 1'b0;
         outst_q <= '0;
      end else begin
         outst_q <= outst_d;
         case (state_q)
            IDLE: begin
               if (pop_c && !hit_c) begin
                  state_q <= ISSUE;
                  req_q   <= 1'b1;
                  addr_q  <= stk_addr_i & LMASK;
               end
            end
            ISSUE: begin
               if (mem_gnt_i || flush_i) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign stk_pop_o  = pop_c;
   assign mem_req_o  = req_q;
   assign mem_addr_o = addr_q;
   assign busy_o     = (state_q != IDLE) | (outst_q != '0);

endmodule

// File: tb/tb_hwpf_issue.sv
// Directed bench for hwpf_issue with a handshake scoreboard (MAX_OUTSTANDING=2).
module tb_hwpf_issue;
   import hwpf_pkg::*;

   logic      clk       = 1'b0;
   logic      rst       = 1'b1;
   logic      flush     = 1'b0;
   logic      stall     = 1'b0;
   logic      stk_valid = 1'b0;
   cpu_addr_t stk_addr  = '0;
   logic      stk_pop;
   logic      mem_req;
   cpu_addr_t mem_addr;
   logic      mem_gnt   = 1'b0;
   logic      mem_rsp   = 1'b0;
   logic      busy;

   int checks = 0;
   int errors = 0;
   cpu_addr_t exp_q[$];

   logic      prev_req  = 1'b0;
   logic      prev_hs   = 1'b0;
   cpu_addr_t prev_addr = '0;

   hwpf_issue #(.MAX_OUTSTANDING(2), .LINE_OFF_BITS(6)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .stall_i     (stall),
      .stk_valid_i (stk_valid),
      .stk_addr_i  (stk_addr),
      .stk_pop_o   (stk_pop),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_gnt_i   (mem_gnt),
      .mem_rsp_i   (mem_rsp),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rsp_pulse();
      mem_rsp = 1'b1;
      step();
      mem_rsp = 1'b0;
   endtask

   // Pop a candidate, watch the request for gnt_wait cycles, then grant it.
   task automatic issue(input cpu_addr_t a, input cpu_addr_t line, input int gnt_wait,
                        input bit with_flush, input bit with_rsp);
      stk_valid = 1'b1;
      stk_addr  = a;
      #1 chk("pop", 64'(stk_pop), 64'd1);
      step();
      stk_valid = 1'b0;
      stk_addr  = '0;
      #1 chk("req_rise", 64'(mem_req), 64'd1);
      chk("req_addr", 64'(mem_addr), 64'(line));
      for (int i = 0; i < gnt_wait; i++) begin
         step();
         chk("req_hold", 64'(mem_req), 64'd1);
      end
      exp_q.push_back(line);
      mem_gnt = 1'b1;
      flush   = with_flush;
      mem_rsp = with_rsp;
      step();
      mem_gnt = 1'b0;
      flush   = 1'b0;
      mem_rsp = 1'b0;
      #1 chk("req_drop", 64'(mem_req), 64'd0);
   endtask

   // Monitor: every accepted handshake must match the next expected line; held address must not move.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && prev_req && !prev_hs) begin
            chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
         end
         if (mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL hs_unexpected act=%0h exp=none t=%0t", mem_addr, $time);
            end else begin
               chk("hs_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
            end
         end
         prev_req  = mem_req;
         prev_addr = mem_addr;
         prev_hs   = mem_req && mem_gnt;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step();
      step();
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_pop", 64'(stk_pop), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();

      // T1: basic issue, grant after 3 held cycles
      issue(40'h1234, 40'h1200, 3, 1'b0, 1'b0);
      chk("t1_outst", 64'(dut.outst_q), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      rsp_pulse();
      #1 chk("t1_outst0", 64'(dut.outst_q), 64'd0);
      chk("t1_busy0", 64'(busy), 64'd0);

      // T2: throttle at MAX_OUTSTANDING=2
      issue(40'h2000, 40'h2000, 0, 1'b0, 1'b0);
      issue(40'h2040, 40'h2040, 0, 1'b0, 1'b0);
      chk("t2_outst2", 64'(dut.outst_q), 64'd2);
      stk_valid = 1'b1;
      stk_addr  = 40'h2080;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t2_blocked", 64'(stk_pop), 64'd0);
         chk("t2_noreq", 64'(mem_req), 64'd0);
         step();
      end
      mem_rsp = 1'b1;
      #1 chk("t2_rsp_cycle", 64'(stk_pop), 64'd0);
      step();
      mem_rsp = 1'b0;
      #1 chk("t2_outst1", 64'(dut.outst_q), 64'd1);
      chk("t2_pop", 64'(stk_pop), 64'd1);
      step();
      stk_valid = 1'b0;
      #1 chk("t2_req", 64'(mem_req), 64'd1);
      chk("t2_addr", 64'(mem_addr), 64'h2080);
      exp_q.push_back(40'h2080);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      #1 chk("t2_outst2b", 64'(dut.outst_q), 64'd2);
      rsp_pulse();
      rsp_pulse();
      #1 chk("t2_drain", 64'(dut.outst_q), 64'd0);

      // T3: flush drops an ungranted request; flush with grant counts
      stk_valid = 1'b1;
      stk_addr  = 40'h3010;
      #1 chk("t3_pop", 64'(stk_pop), 64'd1);
      step();
      stk_valid = 1'b0;
      #1 chk("t3_req", 64'(mem_req), 64'd1);
      chk("t3_addr", 64'(mem_addr), 64'h3000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1 chk("t3_dropped", 64'(mem_req), 64'd0);
      chk("t3_outst0", 64'(dut.outst_q), 64'd0);
      issue(40'h3040, 40'h3040, 1, 1'b1, 1'b0);
      chk("t3_outst1", 64'(dut.outst_q), 64'd1);
      rsp_pulse();
      #1 chk("t3_outst_back", 64'(dut.outst_q), 64'd0);

      // T4: stall blocks pops in IDLE but not a held request
      stall     = 1'b1;
      stk_valid = 1'b1;
      stk_addr  = 40'h4008;
      for (int i = 0; i < 5; i++) begin
         #1 chk("t4_nopop", 64'(stk_pop), 64'd0);
         chk("t4_noreq", 64'(mem_req), 64'd0);
         step();
      end
      stall = 1'b0;
      #1 chk("t4_pop", 64'(stk_pop), 64'd1);
      step();
      stk_valid = 1'b0;
      stall     = 1'b1;
      #1 chk("t4_req", 64'(mem_req), 64'd1);
      chk("t4_addr", 64'(mem_addr), 64'h4000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_held", 64'(mem_req), 64'd1);
      end
      exp_q.push_back(40'h4000);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      stall   = 1'b0;
      #1 chk("t4_drop", 64'(mem_req), 64'd0);
      chk("t4_outst1", 64'(dut.outst_q), 64'd1);

      // T5: gnt+rsp same cycle nets zero; spurious rsp at zero saturates
      issue(40'h5000, 40'h5000, 0, 1'b0, 1'b1);
      chk("t5_net0", 64'(dut.outst_q), 64'd1);
      rsp_pulse();
      #1 chk("t5_outst0", 64'(dut.outst_q), 64'd0);
      chk("t5_busy0", 64'(busy), 64'd0);
      rsp_pulse();
      #1 chk("t5_sat", 64'(dut.outst_q), 64'd0);
      chk("t5_busy_sat", 64'(busy), 64'd0);

`ifdef HWPF_ISSUE_FILTER_EN
      // T6: same-line candidate filtered until flush clears the filter
      issue(40'h1240, 40'h1240, 0, 1'b0, 1'b0);
      stk_valid = 1'b1;
      stk_addr  = 40'h1260;
      #1 chk("t6_pop_filtered", 64'(stk_pop), 64'd1);
      step();
      stk_valid = 1'b0;
      #1 chk("t6_noreq", 64'(mem_req), 64'd0);
      step();
      chk("t6_noreq2", 64'(mem_req), 64'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      issue(40'h1260, 40'h1240, 0, 1'b0, 1'b0);
      chk("t6_outst2", 64'(dut.outst_q), 64'd2);
      rsp_pulse();
      rsp_pulse();
`endif

      step();
      step();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
